mem_arbiter: RTL and testbench

- Dynamic round-robin arbiter placed between up to NREQ memory clients and the single memory_unit port.
- Clients are the traversal unit and the execute, cell, incr and equal blocks.
- Replaces static select-driven muxing: each client issues one memory transaction through a req/ack handshake, and the arbiter owns the execute/is_ready protocol to memory_unit.
- Supports a per-client lock for multi-transaction atomic sequences (read-modify-write of a cell) and a busy watchdog.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, memory func codes,
// default sizing and a one-hot decode helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_BUSY     = 2'd2,
        ST_COMPLETE = 2'd3
    } arb_state_t;

    localparam logic [1:0] FUNC_NOP   = 2'b00;
    localparam logic [1:0] FUNC_READ  = 2'b01;
    localparam logic [1:0] FUNC_WRITE = 2'b10;
    localparam logic [1:0] FUNC_COPY  = 2'b11;

    localparam int DEFAULT_NREQ   = 5;
    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 16;

    // Index of the set bit of a one-hot vector (up to 32 clients); 0 when empty.
    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'pointer',
// wrapping modulo NREQ.
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    // rot_idx[k] is the client examined k-th in priority order.
    logic [PW-1:0] rot_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_idx[gi] = PW'((32'(pointer) + 32'(gi) + 32'd1) % 32'(NREQ));
        end
    endgenerate

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[rot_idx[i]]) begin
                winner[rot_idx[i]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises client transactions onto the single
// memory_unit execute/is_ready port, with per-client lock and a busy watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [2*NREQ-1:0]      req_func,
    input  logic [ADDR_W*NREQ-1:0] req_addr1,
    input  logic [ADDR_W*NREQ-1:0] req_addr2,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic [1:0]             mem_func,
    output logic                   mem_execute,
    output logic [ADDR_W-1:0]      mem_addr1,
    output logic [ADDR_W-1:0]      mem_addr2,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ready,
    input  logic [DATA_W-1:0]      mem_rdata1,
    input  logic [DATA_W-1:0]      mem_rdata2
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    // Per-client views of the flattened command buses.
    logic [1:0]        func_arr  [NREQ];
    logic [ADDR_W-1:0] addr1_arr [NREQ];
    logic [ADDR_W-1:0] addr2_arr [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign func_arr[gi]  = req_func[2*gi +: 2];
            assign addr1_arr[gi] = req_addr1[ADDR_W*gi +: ADDR_W];
            assign addr2_arr[gi] = req_addr2[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
        end
    endgenerate

    arb_state_t        state_reg, state_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic              pinned_reg, pinned_next;
    logic [WDW-1:0]    wd_reg, wd_next;
    logic              fell_reg, fell_next;
    logic              err_reg, err_next;
    logic [1:0]        func_reg, func_next;
    logic [ADDR_W-1:0] addr1_reg, addr1_next;
    logic [ADDR_W-1:0] addr2_reg, addr2_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rd1_reg, rd1_next;
    logic [DATA_W-1:0] rd2_reg, rd2_next;

    logic [NREQ-1:0] pick_winner;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   owner_idx;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .pointer (ptr_reg),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    assign pick_idx  = PW'(onehot_to_idx(32'(pick_winner)));
    assign owner_idx = PW'(onehot_to_idx(32'(grant_reg)));

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ptr_next    = ptr_reg;
        pinned_next = pinned_reg;
        wd_next     = wd_reg;
        fell_next   = fell_reg;
        err_next    = err_reg;
        func_next   = func_reg;
        addr1_next  = addr1_reg;
        addr2_next  = addr2_reg;
        wdata_next  = wdata_reg;
        rd1_next    = rd1_reg;
        rd2_next    = rd2_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pinned_reg && req[owner_idx]) begin
                    // Locked owner keeps the grant; it only waits for memory.
                    if (mem_ready) begin
                        func_next  = func_arr[owner_idx];
                        addr1_next = addr1_arr[owner_idx];
                        addr2_next = addr2_arr[owner_idx];
                        wdata_next = wdata_arr[owner_idx];
                        state_next = ST_ISSUE;
                    end
                end else begin
                    // Owner dropped req (or none pinned): normal round-robin.
                    pinned_next = 1'b0;
                    grant_next  = '0;
                    if (mem_ready && pick_valid) begin
                        grant_next = pick_winner;
                        func_next  = func_arr[pick_idx];
                        addr1_next = addr1_arr[pick_idx];
                        addr2_next = addr2_arr[pick_idx];
                        wdata_next = wdata_arr[pick_idx];
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                fell_next  = !mem_ready;
                wd_next    = '0;
                err_next   = 1'b0;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (!mem_ready) fell_next = 1'b1;
                if (fell_reg && mem_ready) begin
                    rd1_next   = mem_rdata1;
                    rd2_next   = mem_rdata2;
                    state_next = ST_COMPLETE;
                end else if (wd_reg == WDW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_COMPLETE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_COMPLETE: begin
                ptr_next = owner_idx;
                wd_next  = '0;
                if (lock[owner_idx] && req[owner_idx]) begin
                    pinned_next = 1'b1;
                end else begin
                    pinned_next = 1'b0;
                    grant_next  = '0;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            ptr_reg    <= PW'(NREQ - 1);
            pinned_reg <= 1'b0;
            wd_reg     <= '0;
            fell_reg   <= 1'b0;
            err_reg    <= 1'b0;
            func_reg   <= '0;
            addr1_reg  <= '0;
            addr2_reg  <= '0;
            wdata_reg  <= '0;
            rd1_reg    <= '0;
            rd2_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            pinned_reg <= pinned_next;
            wd_reg     <= wd_next;
            fell_reg   <= fell_next;
            err_reg    <= err_next;
            func_reg   <= func_next;
            addr1_reg  <= addr1_next;
            addr2_reg  <= addr2_next;
            wdata_reg  <= wdata_next;
            rd1_reg    <= rd1_next;
            rd2_reg    <= rd2_next;
        end
    end

    assign grant       = grant_reg;
    assign ack         = (state_reg == ST_COMPLETE) ? grant_reg : '0;
    assign err         = (state_reg == ST_COMPLETE) && err_reg;
    assign rd_data1    = rd1_reg;
    assign rd_data2    = rd2_reg;
    assign mem_execute = (state_reg == ST_ISSUE);
    assign mem_func    = func_reg;
    assign mem_addr1   = addr1_reg;
    assign mem_addr2   = addr2_reg;
    assign mem_wdata   = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed client traffic against a
// behavioural memory_unit model with configurable hang.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NREQ = 5;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    req, lock, grant, ack;
    logic [2*NREQ-1:0]  req_func;
    logic [AW*NREQ-1:0] req_addr1, req_addr2;
    logic [DW*NREQ-1:0] req_wdata;
    logic               err;
    logic [DW-1:0]      rd_data1, rd_data2;
    logic [1:0]         mem_func;
    logic               mem_execute;
    logic [AW-1:0]      mem_addr1, mem_addr2;
    logic [DW-1:0]      mem_wdata;
    logic               mem_ready;
    logic [DW-1:0]      mem_rdata1, mem_rdata2;

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_func(req_func), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_wdata(req_wdata), .grant(grant), .ack(ack), .err(err),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .mem_func(mem_func),
        .mem_execute(mem_execute), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // ---------------- checking bookkeeping ----------------
    int chk_total = 0;
    int chk_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // ---------------- client side ----------------
    // A client requests while it has more transactions issued than acked.
    int              issued [NREQ];
    int              acked  [NREQ];
    logic [NREQ-1:0] lock_want;
    logic [1:0]      c_func [NREQ];
    logic [AW-1:0]   c_a1   [NREQ];
    logic [AW-1:0]   c_a2   [NREQ];
    logic [DW-1:0]   c_wd   [NREQ];

    always_comb begin
        req       = '0;
        req_func  = '0;
        req_addr1 = '0;
        req_addr2 = '0;
        req_wdata = '0;
        for (int c = 0; c < NREQ; c++) begin
            req[c]                 = (issued[c] != acked[c]);
            req_func[2*c +: 2]     = c_func[c];
            req_addr1[AW*c +: AW]  = c_a1[c];
            req_addr2[AW*c +: AW]  = c_a2[c];
            req_wdata[DW*c +: DW]  = c_wd[c];
        end
    end
    assign lock = lock_want;

    // ---------------- memory_unit model ----------------
    function automatic logic [DW-1:0] mdata1(input logic [AW-1:0] a);
        return {6'h15, a};
    endfunction
    function automatic logic [DW-1:0] mdata2(input logic [AW-1:0] a);
        return 16'hC000 ^ {6'h00, a};
    endfunction

    logic          busy_m, model_ready, hang, idle_ready;
    int            cnt, exec_count, exec_cycle;
    logic [AW-1:0] exec_a1, exec_a2;
    logic [1:0]    exec_func;

    assign mem_ready = busy_m ? model_ready : idle_ready;

    initial begin
        busy_m = 1'b0; model_ready = 1'b1; cnt = 0; exec_count = 0; exec_cycle = 0;
        exec_a1 = '0; exec_a2 = '0; exec_func = '0; mem_rdata1 = '0; mem_rdata2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_m = 1'b0; model_ready = 1'b1;
            end else if (mem_execute) begin
                busy_m = 1'b1; model_ready = 1'b0; cnt = 4;
                exec_count++; exec_cycle = cycle;
                exec_a1 = mem_addr1; exec_a2 = mem_addr2; exec_func = mem_func;
            end else if (busy_m && !hang) begin
                if (cnt <= 1) begin
                    model_ready = 1'b1; busy_m = 1'b0;
                    mem_rdata1 = mdata1(exec_a1);
                    mem_rdata2 = mdata2(exec_a2);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            client;
        logic          err;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_last1, exp_last2;
    int            ack_cycle;

    // An aborted transaction leaves rd_data at the last good read.
    task automatic expect_ack(input int c, input logic e);
        exp_t x;
        if (!e) begin
            exp_last1 = mdata1(c_a1[c]);
            exp_last2 = mdata2(c_a2[c]);
        end
        x.client = c; x.err = e; x.rd1 = exp_last1; x.rd2 = exp_last2;
        sb.push_back(x);
    endtask

    initial begin
        exp_t e;
        for (int c = 0; c < NREQ; c++) acked[c] = 0;
        ack_cycle = 0;
        forever begin
            @(negedge clk);
            if (ack != '0) begin
                ack_cycle = cycle;
                $display("ack %b err %0b rd1 %h rd2 %h at cycle %0d", ack, err, rd_data1, rd_data2, cycle);
                check("grant_matches_ack", 32'(grant), 32'(ack));
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_client", 32'(ack), 32'd1 << e.client);
                    check("ack_err", 32'(err), 32'(e.err));
                    check("rd_data1", 32'(rd_data1), 32'(e.rd1));
                    check("rd_data2", 32'(rd_data2), 32'(e.rd2));
                end
                for (int c = 0; c < NREQ; c++) if (ack[c]) acked[c]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_pending"}, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_exec(input string name, input int budget);
        int n = 0;
        while (!mem_execute && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_exec_seen"}, 32'(mem_execute), 32'd1);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; hang = 1'b0; idle_ready = 1'b1; lock_want = '0;
        for (int c = 0; c < NREQ; c++) issued[c] = acked[c];
        @(negedge clk);
        check({name, "_grant"}, 32'(grant), 32'd0);
        check({name, "_ack"}, 32'(ack), 32'd0);
        check({name, "_exec"}, 32'(mem_execute), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_last1 = '0; exp_last2 = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        hang = 1'b0; idle_ready = 1'b1; lock_want = '0;
        exp_last1 = '0; exp_last2 = '0;
        for (int c = 0; c < NREQ; c++) begin
            issued[c] = 0;
            c_func[c] = FUNC_READ;
            c_a1[c]   = AW'(10'h100 + 10'(16 * c));
            c_a2[c]   = AW'(10'h200 + 10'(3 * c));
            c_wd[c]   = DW'(16'hA000 + 16'(c));
        end

        // Reset state
        do_reset("reset");
        check("reset_mem_addr1", 32'(mem_addr1), 32'd0);
        check("reset_rd_data1", 32'(rd_data1), 32'd0);
        check("reset_mem_func", 32'(mem_func), 32'd0);

        // Single request from client 2
        c_a1[2] = 10'h012; c_a2[2] = 10'h034;
        base = exec_count;
        expect_ack(2, 1'b0);
        issued[2]++;
        drain("single", 60);
        check("single_exec_count", 32'(exec_count - base), 32'd1);
        check("single_exec_addr1", 32'(exec_a1), 32'h012);
        check("single_exec_func", 32'(exec_func), 32'(FUNC_READ));

        // Lock: pointer now at 2, so client 3 wins and keeps three transactions
        c_a1[3] = 10'h0A3;
        expect_ack(3, 1'b0); expect_ack(3, 1'b0); expect_ack(3, 1'b0); expect_ack(1, 1'b0);
        lock_want[3] = 1'b1;
        issued[3] += 3;
        issued[1]++;
        drain("lock", 300);
        lock_want[3] = 1'b0;

        // Round-robin contention from fresh reset
        do_reset("reset2");
        expect_ack(0, 1'b0); expect_ack(1, 1'b0); expect_ack(2, 1'b0);
        expect_ack(3, 1'b0); expect_ack(4, 1'b0); expect_ack(0, 1'b0);
        issued[0] += 2;
        for (int c = 1; c < NREQ; c++) issued[c]++;
        drain("rr", 400);

        // Watchdog: memory never completes
        hang = 1'b1;
        base = exec_count;
        expect_ack(4, 1'b1);
        issued[4]++;
        drain("wdog", 200);
        check("wdog_latency", 32'(ack_cycle - exec_cycle), 32'd17);
        check("wdog_exec_count", 32'(exec_count - base), 32'd1);
        hang = 1'b0;
        repeat (10) @(negedge clk);

        // Not-ready gating
        idle_ready = 1'b0;
        expect_ack(0, 1'b0);
        issued[0]++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("notready_grant", 32'(grant), 32'd0);
            check("notready_exec", 32'(mem_execute), 32'd0);
        end
        idle_ready = 1'b1;
        @(negedge clk);
        check("ready_grant", 32'(grant), 32'd1);
        drain("notready", 60);

        // Reset during BUSY; the aborted client must never see an ack
        hang = 1'b1;
        issued[2]++;
        wait_exec("midrst", 20);
        repeat (3) @(negedge clk);
        rst = 1'b1; hang = 1'b0;
        for (int c = 0; c < NREQ; c++) issued[c] = acked[c];
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_exec", 32'(mem_execute), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_last1 = '0; exp_last2 = '0;
        expect_ack(0, 1'b0); expect_ack(3, 1'b0);
        issued[3]++;
        issued[0]++;
        drain("postrst", 120);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
